rob_commit: RTL and testbench

- In-order reorder buffer and retire stage. Accepts dispatched instructions in program order, records out-of-order writeback results and store address/data, and retires at most one completed instruction per cycle from the head.
- Its commit bus (valid, pc, inst, Ard, data, store addr/data/mask) feeds the commit logger and the store buffer directly downstream.

---
 rtl/rob_pkg.sv | 39 +++
 rtl/rob_ptr_ctrl.sv | 49 ++++
 rtl/rob_commit.sv | 134 +++++++++++++
 tb/tb_rob_commit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared types and opcode constants for the reorder buffer / retire stage.
package rob_pkg;

  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;

  // Per-entry payload; valid/done live in separate resettable flops.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [5:0]  ard;
    logic        is_store;
    logic [31:0] data;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [3:0]  mask;
  } rob_entry_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [5:0]  ard;
    logic [31:0] data;
    logic        st;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_mask;
  } commit_bus_t;

  function automatic logic is_store_op(input logic [31:0] inst);
    return inst[6:2] == OPC_STORE;
  endfunction

  function automatic logic is_branch_op(input logic [31:0] inst);
    return inst[6:2] == OPC_BRANCH;
  endfunction

endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the ROB; decides dispatch and commit firing.
module rob_ptr_ctrl #(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             dis_valid,
  input  logic             head_ok,
  output logic [IDX_W-1:0] head,
  output logic [IDX_W-1:0] tail,
  output logic             dis_ready,
  output logic             empty,
  output logic             dispatch_fire,
  output logic             commit_fire
);

  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

  logic [IDX_W-1:0] head_reg, tail_reg;
  logic [IDX_W:0]   count_reg;

  // Full is judged on the registered count only: no bypass from a same-cycle commit.
  assign dis_ready     = (count_reg != FULL_CNT);
  assign empty         = (count_reg == '0);
  assign dispatch_fire = dis_valid && dis_ready && !flush;
  assign commit_fire   = head_ok && !flush;
  assign head          = head_reg;
  assign tail          = tail_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (commit_fire)   head_reg <= head_reg + 1'b1;
      if (dispatch_fire) tail_reg <= tail_reg + 1'b1;
      if (dispatch_fire && !commit_fire)      count_reg <= count_reg + 1'b1;
      else if (!dispatch_fire && commit_fire) count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/rob_commit.sv
// In-order reorder buffer: records out-of-order results, retires one entry per cycle from the head.
module rob_commit
  import rob_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             dis_valid,
  output logic             dis_ready,
  input  logic [31:0]      dis_pc,
  input  logic [31:0]      dis_inst,
  input  logic [5:0]       dis_Ard,
  output logic [IDX_W-1:0] dis_idx,
  input  logic             wb_valid,
  input  logic [IDX_W-1:0] wb_idx,
  input  logic [31:0]      wb_data,
  input  logic             sw_valid,
  input  logic [IDX_W-1:0] sw_idx,
  input  logic [31:0]      sw_addr,
  input  logic [31:0]      sw_data,
  input  logic [3:0]       sw_mask,
  input  logic             st_ready,
  output logic             commit_valid,
  output logic [31:0]      commit_pc,
  output logic [31:0]      commit_inst,
  output logic [5:0]       commit_Ard,
  output logic [31:0]      commit_data,
  output logic             st_commit,
  output logic [31:0]      st_addr,
  output logic [31:0]      st_data,
  output logic [3:0]       st_mask,
  output logic             empty
);

  logic [IDX_W-1:0] head, tail;
  logic             dispatch_fire, commit_fire, head_ok;
  logic             wb_en, sw_en;
  logic [DEPTH-1:0] valid_reg, done_reg;
  rob_entry_t       entry_mem [DEPTH];
  rob_entry_t       head_entry;
  commit_bus_t      bus;

  rob_ptr_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_ptr (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .dis_valid     (dis_valid),
    .head_ok       (head_ok),
    .head          (head),
    .tail          (tail),
    .dis_ready     (dis_ready),
    .empty         (empty),
    .dispatch_fire (dispatch_fire),
    .commit_fire   (commit_fire)
  );

  assign dis_idx    = tail;
  assign head_entry = entry_mem[head];
  assign head_ok    = valid_reg[head] && done_reg[head] && (!head_entry.is_store || st_ready);
  assign wb_en      = wb_valid && !flush && valid_reg[wb_idx];
  assign sw_en      = sw_valid && !flush && valid_reg[sw_idx];

  // Payload storage is not reset; only valid/done gate its use.
  always_ff @(posedge clk) begin
    if (dispatch_fire) begin
      entry_mem[tail].pc       <= dis_pc;
      entry_mem[tail].inst     <= dis_inst;
      entry_mem[tail].is_store <= is_store_op(dis_inst);
      entry_mem[tail].ard      <= (is_store_op(dis_inst) || is_branch_op(dis_inst)) ? 6'd0 : dis_Ard;
    end
    if (wb_en) entry_mem[wb_idx].data <= wb_data;
    if (sw_en) begin
      entry_mem[sw_idx].addr  <= sw_addr;
      entry_mem[sw_idx].sdata <= sw_data;
      entry_mem[sw_idx].mask  <= sw_mask;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_status
    logic v_reg, d_reg;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v_reg <= 1'b0;
        d_reg <= 1'b0;
      end else if (flush) begin
        v_reg <= 1'b0;
        d_reg <= 1'b0;
      end else begin
        if (dispatch_fire && tail == IDX_W'(gi)) begin
          v_reg <= 1'b1;
          d_reg <= 1'b0;
        end else if (commit_fire && head == IDX_W'(gi)) begin
          v_reg <= 1'b0;
        end
        if ((wb_en && wb_idx == IDX_W'(gi)) || (sw_en && sw_idx == IDX_W'(gi))) d_reg <= 1'b1;
      end
    end

    assign valid_reg[gi] = v_reg;
    assign done_reg[gi]  = d_reg;
  end

  always_comb begin
    bus = '0;
    if (commit_fire) begin
      bus.valid = 1'b1;
      bus.pc    = head_entry.pc;
      bus.inst  = head_entry.inst;
      bus.ard   = head_entry.ard;
      bus.data  = head_entry.data;
      if (head_entry.is_store) begin
        bus.st      = 1'b1;
        bus.st_addr = head_entry.addr;
        bus.st_data = head_entry.sdata;
        bus.st_mask = head_entry.mask;
      end
    end
  end

  assign commit_valid = bus.valid;
  assign commit_pc    = bus.pc;
  assign commit_inst  = bus.inst;
  assign commit_Ard   = bus.ard;
  assign commit_data  = bus.data;
  assign st_commit    = bus.st;
  assign st_addr      = bus.st_addr;
  assign st_data      = bus.st_data;
  assign st_mask      = bus.st_mask;

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit (DEPTH=4): per-cycle vector table plus store-stall and reset sequences.
module tb_rob_commit;

  localparam int DEPTH = 4;
  localparam int IDX_W = 2;
  localparam logic [31:0] I_ALU = 32'h00500093;
  localparam logic [31:0] I_BR  = 32'h00208463;
  localparam logic [31:0] I_ST  = 32'h00f12023;

  logic             clk, rst, flush;
  logic             dis_valid, dis_ready;
  logic [31:0]      dis_pc, dis_inst;
  logic [5:0]       dis_Ard;
  logic [IDX_W-1:0] dis_idx;
  logic             wb_valid;
  logic [IDX_W-1:0] wb_idx;
  logic [31:0]      wb_data;
  logic             sw_valid;
  logic [IDX_W-1:0] sw_idx;
  logic [31:0]      sw_addr, sw_data;
  logic [3:0]       sw_mask;
  logic             st_ready;
  logic             commit_valid, st_commit, empty;
  logic [31:0]      commit_pc, commit_inst, commit_data, st_addr, st_data;
  logic [5:0]       commit_Ard;
  logic [3:0]       st_mask;

  int n_cmp = 0;
  int n_bad = 0;

  rob_commit #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dis_valid(dis_valid), .dis_ready(dis_ready), .dis_pc(dis_pc), .dis_inst(dis_inst),
    .dis_Ard(dis_Ard), .dis_idx(dis_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
    .sw_valid(sw_valid), .sw_idx(sw_idx), .sw_addr(sw_addr), .sw_data(sw_data), .sw_mask(sw_mask),
    .st_ready(st_ready),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
    .commit_Ard(commit_Ard), .commit_data(commit_data),
    .st_commit(st_commit), .st_addr(st_addr), .st_data(st_data), .st_mask(st_mask),
    .empty(empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (rst && wb_valid && sw_valid)
      assert (wb_idx != sw_idx) else $error("wb and sw target the same entry %0d", wb_idx);
  end

  typedef struct {
    logic             dv;
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic [5:0]       ard;
    logic             wv;
    logic [IDX_W-1:0] wi;
    logic [31:0]      wd;
    logic             fl;
    logic             e_rdy;
    logic [IDX_W-1:0] e_idx;
    logic             e_cv;
    logic [31:0]      e_pc;
    logic [5:0]       e_ard;
    logic [31:0]      e_data;
    logic             e_empty;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic dv, logic [31:0] pc, logic [31:0] inst, logic [5:0] ard,
                              logic wv, logic [IDX_W-1:0] wi, logic [31:0] wd, logic fl,
                              logic e_rdy, logic [IDX_W-1:0] e_idx, logic e_cv, logic [31:0] e_pc,
                              logic [5:0] e_ard, logic [31:0] e_data, logic e_empty);
    vec_t v;
    v = '{dv, pc, inst, ard, wv, wi, wd, fl, e_rdy, e_idx, e_cv, e_pc, e_ard, e_data, e_empty};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    dis_valid = 1'b0;
    wb_valid  = 1'b0;
    sw_valid  = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; dis_valid = 1'b0; dis_pc = '0; dis_inst = '0; dis_Ard = '0;
    wb_valid = 1'b0; wb_idx = '0; wb_data = '0; sw_valid = 1'b0; sw_idx = '0;
    sw_addr = '0; sw_data = '0; sw_mask = '0; st_ready = 1'b1;

    #2;
    chk("reset_dis_ready", dis_ready, 1);
    chk("reset_dis_idx", dis_idx, 0);
    chk("reset_commit_valid", commit_valid, 0);
    chk("reset_st_commit", st_commit, 0);
    chk("reset_empty", empty, 1);
    chk("reset_commit_pc", commit_pc, 0);
    $display("reset: dis_ready=%b empty=%b commit_valid=%b", dis_ready, empty, commit_valid);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // dv pc inst ard | wv wi wd | fl || rdy idx cv pc ard data empty
    tbl.push_back(mk(1, 32'h2000, I_ALU, 1,  0, 0, 0,     0, 1, 0, 0, 0,      0, 0,     1));
    tbl.push_back(mk(0, 0,        0,     0,  1, 0, 5,     0, 1, 1, 0, 0,      0, 0,     0));
    tbl.push_back(mk(0, 0,        0,     0,  0, 0, 0,     0, 1, 1, 1, 32'h2000, 1, 5,   0));
    tbl.push_back(mk(1, 32'h100,  I_ALU, 2,  0, 0, 0,     0, 1, 1, 0, 0,      0, 0,     1));
    tbl.push_back(mk(1, 32'h104,  I_ALU, 3,  0, 0, 0,     0, 1, 2, 0, 0,      0, 0,     0));
    tbl.push_back(mk(1, 32'h108,  I_BR,  4,  0, 0, 0,     0, 1, 3, 0, 0,      0, 0,     0));
    tbl.push_back(mk(0, 0,        0,     0,  1, 3, 'h33,  0, 1, 0, 0, 0,      0, 0,     0));
    tbl.push_back(mk(0, 0,        0,     0,  1, 2, 'h22,  0, 1, 0, 0, 0,      0, 0,     0));
    tbl.push_back(mk(0, 0,        0,     0,  1, 1, 'h11,  0, 1, 0, 0, 0,      0, 0,     0));
    tbl.push_back(mk(0, 0,        0,     0,  0, 0, 0,     0, 1, 0, 1, 32'h100, 2, 'h11, 0));
    tbl.push_back(mk(0, 0,        0,     0,  0, 0, 0,     0, 1, 0, 1, 32'h104, 3, 'h22, 0));
    tbl.push_back(mk(0, 0,        0,     0,  0, 0, 0,     0, 1, 0, 1, 32'h108, 0, 'h33, 0));
    tbl.push_back(mk(0, 0,        0,     0,  0, 0, 0,     0, 1, 0, 0, 0,      0, 0,     1));
    tbl.push_back(mk(1, 32'h200,  I_ALU, 5,  0, 0, 0,     0, 1, 0, 0, 0,      0, 0,     1));
    tbl.push_back(mk(1, 32'h204,  I_ALU, 6,  0, 0, 0,     0, 1, 1, 0, 0,      0, 0,     0));
    tbl.push_back(mk(1, 32'h208,  I_ALU, 7,  0, 0, 0,     0, 1, 2, 0, 0,      0, 0,     0));
    tbl.push_back(mk(1, 32'h20c,  I_ALU, 8,  0, 0, 0,     0, 1, 3, 0, 0,      0, 0,     0));
    tbl.push_back(mk(1, 32'h210,  I_ALU, 9,  1, 0, 'hA0,  0, 0, 0, 0, 0,      0, 0,     0));
    tbl.push_back(mk(1, 32'h210,  I_ALU, 9,  0, 0, 0,     0, 0, 0, 1, 32'h200, 5, 'hA0, 0));
    tbl.push_back(mk(1, 32'h210,  I_ALU, 9,  0, 0, 0,     0, 1, 0, 0, 0,      0, 0,     0));
    tbl.push_back(mk(0, 0,        0,     0,  1, 1, 'hB1,  0, 0, 1, 0, 0,      0, 0,     0));
    tbl.push_back(mk(0, 0,        0,     0,  0, 0, 0,     1, 0, 1, 0, 0,      0, 0,     0));
    tbl.push_back(mk(0, 0,        0,     0,  1, 1, 'hEE,  0, 1, 0, 0, 0,      0, 0,     1));
    tbl.push_back(mk(1, 32'h300,  I_ALU, 10, 0, 0, 0,     0, 1, 0, 0, 0,      0, 0,     1));
    tbl.push_back(mk(1, 32'h304,  I_ALU, 11, 1, 0, 'h77,  0, 1, 1, 0, 0,      0, 0,     0));
    tbl.push_back(mk(0, 0,        0,     0,  0, 0, 0,     0, 1, 2, 1, 32'h300, 10, 'h77, 0));
    tbl.push_back(mk(0, 0,        0,     0,  0, 0, 0,     0, 1, 2, 0, 0,      0, 0,     0));

    foreach (tbl[i]) begin
      @(negedge clk);
      dis_valid = tbl[i].dv; dis_pc = tbl[i].pc; dis_inst = tbl[i].inst; dis_Ard = tbl[i].ard;
      wb_valid = tbl[i].wv; wb_idx = tbl[i].wi; wb_data = tbl[i].wd; flush = tbl[i].fl;
      sw_valid = 1'b0; st_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_dis_ready", i), dis_ready, tbl[i].e_rdy);
      chk($sformatf("v%0d_dis_idx", i), dis_idx, tbl[i].e_idx);
      chk($sformatf("v%0d_commit_valid", i), commit_valid, tbl[i].e_cv);
      chk($sformatf("v%0d_commit_pc", i), commit_pc, tbl[i].e_pc);
      chk($sformatf("v%0d_commit_Ard", i), commit_Ard, tbl[i].e_ard);
      chk($sformatf("v%0d_commit_data", i), commit_data, tbl[i].e_data);
      chk($sformatf("v%0d_st_commit", i), st_commit, 0);
      chk($sformatf("v%0d_empty", i), empty, tbl[i].e_empty);
      $display("vec %0d: dis_ready=%b dis_idx=%0d commit_valid=%b pc=0x%0h Ard=%0d data=0x%0h empty=%b",
               i, dis_ready, dis_idx, commit_valid, commit_pc, commit_Ard, commit_data, empty);
    end

    // Store stall: clean up with a flush, then a store followed by a younger ALU op.
    nxt(); flush = 1'b1; #1;
    chk("st_flush_commit_valid", commit_valid, 0);
    nxt(); st_ready = 1'b0;
    dis_valid = 1'b1; dis_pc = 32'h400; dis_inst = I_ST; dis_Ard = 6'd7; #1;
    chk("st_dis_idx", dis_idx, 0);
    nxt(); dis_valid = 1'b1; dis_pc = 32'h404; dis_inst = I_ALU; dis_Ard = 6'd12;
    sw_valid = 1'b1; sw_idx = 0; sw_addr = 32'h808c; sw_data = 32'h12345678; sw_mask = 4'hF; #1;
    chk("st_alu_dis_idx", dis_idx, 1);
    chk("st_pre_commit_valid", commit_valid, 0);
    nxt(); wb_valid = 1'b1; wb_idx = 1; wb_data = 32'h99; #1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin nxt(); #1; end
      chk($sformatf("st_stall%0d_commit_valid", k), commit_valid, 0);
      chk($sformatf("st_stall%0d_st_commit", k), st_commit, 0);
      $display("store stall %0d: commit_valid=%b st_commit=%b", k, commit_valid, st_commit);
    end
    nxt(); st_ready = 1'b1; #1;
    chk("st_commit_valid", commit_valid, 1);
    chk("st_st_commit", st_commit, 1);
    chk("st_commit_pc", commit_pc, 32'h400);
    chk("st_commit_inst", commit_inst, I_ST);
    chk("st_commit_Ard", commit_Ard, 0);
    chk("st_addr", st_addr, 32'h808c);
    chk("st_data", st_data, 32'h12345678);
    chk("st_mask", st_mask, 4'hF);
    $display("store commit: st_commit=%b addr=0x%0h data=0x%0h mask=0x%0h", st_commit, st_addr, st_data, st_mask);
    nxt(); #1;
    chk("st_next_commit_valid", commit_valid, 1);
    chk("st_next_st_commit", st_commit, 0);
    chk("st_next_commit_pc", commit_pc, 32'h404);
    chk("st_next_commit_Ard", commit_Ard, 12);
    chk("st_next_commit_data", commit_data, 32'h99);
    chk("st_next_st_addr", st_addr, 0);
    $display("younger commit: pc=0x%0h Ard=%0d data=0x%0h", commit_pc, commit_Ard, commit_data);
    nxt(); #1;
    chk("st_drained_empty", empty, 1);

    // Asynchronous reset while a store is retiring.
    dis_valid = 1'b1; dis_pc = 32'h500; dis_inst = I_ST; dis_Ard = 6'd0; #1;
    chk("rst_dis_idx", dis_idx, 2);
    nxt(); sw_valid = 1'b1; sw_idx = 2; sw_addr = 32'h1000; sw_data = 32'hdead; sw_mask = 4'h3;
    nxt(); #1;
    chk("rst_pre_commit_valid", commit_valid, 1);
    chk("rst_pre_st_commit", st_commit, 1);
    chk("rst_pre_st_addr", st_addr, 32'h1000);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_commit_valid", commit_valid, 0);
    chk("rst_mid_st_commit", st_commit, 0);
    chk("rst_mid_empty", empty, 1);
    chk("rst_mid_dis_ready", dis_ready, 1);
    chk("rst_mid_dis_idx", dis_idx, 0);
    chk("rst_mid_st_addr", st_addr, 0);
    chk("rst_mid_commit_pc", commit_pc, 0);
    $display("mid reset: commit_valid=%b st_commit=%b empty=%b", commit_valid, st_commit, empty);
    @(negedge clk); rst = 1'b1; #1;
    chk("rst_post_empty", empty, 1);
    chk("rst_post_commit_valid", commit_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
